rand_range_gen: RTL and testbench

//  Downstream consumer of the 16-bit XNOR LFSR step (taps 15,14,12,3). Owns the LFSR state

---
 rtl/rand_range_gen_if.sv | 13 +
 rtl/rand_range_gen.sv | 95 +++++++++
 tb/tb_rand_range_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rand_range_gen_if.sv
// rand_range_gen_if: valid/ready stream that carries bounded random values to game logic
//   rnd_valid  producer -> consumer  rnd_data holds an accepted value
//   rnd_ready  consumer -> producer  consumer takes rnd_data on a cycle with rnd_valid=1
//   rnd_data   producer -> consumer  random value, OUT_W bits
interface rand_range_gen_if #(
   parameter int OUT_W = 8
);
   logic             rnd_valid;
   logic             rnd_ready;
   logic [OUT_W-1:0] rnd_data;
   modport master (output rnd_valid, output rnd_data, input rnd_ready);
   modport slave  (input rnd_valid, input rnd_data, output rnd_ready);
endinterface

// File: rtl/rand_range_gen.sv
// rand_range_gen: 16-bit XNOR LFSR (taps 15,14,12,3) reduced by mask-and-reject to an unbiased value in [0,bound]
//   clk          single clock, all state on posedge
//   reset        asynchronous, active-high
//   seed_load    synchronous reseed strobe (highest priority), seed_in is the new LFSR state
//   bound        inclusive upper limit of the output, sampled while filling only
//   rnd          stream master: rnd_valid / rnd_ready / rnd_data
//   lfsr_state   current LFSR state register
//   reject_cnt   rejected candidates, saturating at 16'hFFFF
//   lockup_flag  sticky: the all-ones lockup state was recovered
// Build option RNG_LOCKUP_RECOVER_EN: when defined, an all-ones state seen while filling is
//   replaced by DEFAULT_SEED and lockup_flag is set; otherwise lockup_flag stays 0.
module rand_range_gen #(
   parameter int          OUT_W        = 8,
   parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seed_load,
   input  logic [15:0]      seed_in,
   input  logic [OUT_W-1:0] bound,
   rand_range_gen_if.master rnd,
   output logic [15:0]      lfsr_state,
   output logic [15:0]      reject_cnt,
   output logic             lockup_flag
);
   typedef enum logic {FILL, VALID} state_t;
   state_t           st, st_n;
   logic [15:0]      lfsr_n, rej_n, step;
   logic [OUT_W-1:0] mask, cand, data_q, data_n;
   logic             valid_q, valid_n, lock_n, lockup;
   assign step = {lfsr_state[14:0], lfsr_state[15] ~^ lfsr_state[14] ~^ lfsr_state[12] ~^ lfsr_state[3]};
   // smallest all-ones mask covering bound, so every candidate is equally likely
   always_comb begin
      mask = '0;
      for (int i = 0; i < OUT_W; i++) mask[i] = |(bound >> i);
   end
   assign cand = lfsr_state[OUT_W-1:0] & mask;
`ifdef RNG_LOCKUP_RECOVER_EN
   assign lockup = (lfsr_state == 16'hFFFF);
`else
   assign lockup = 1'b0;
`endif
   always_comb begin
      st_n    = st;
      lfsr_n  = lfsr_state;
      data_n  = data_q;
      valid_n = valid_q;
      rej_n   = reject_cnt;
      lock_n  = lockup_flag;
      if (seed_load) begin
         st_n    = FILL;
         lfsr_n  = seed_in;
         valid_n = 1'b0;
         rej_n   = '0;
         lock_n  = 1'b0;
      end else if (st == FILL) begin
         if (lockup) begin
            // recovery cycle neither accepts nor rejects
            lfsr_n = DEFAULT_SEED;
            lock_n = 1'b1;
         end else begin
            lfsr_n = step;
            if (cand <= bound) begin
               data_n  = cand;
               valid_n = 1'b1;
               st_n    = VALID;
            end else begin
               rej_n = (reject_cnt == 16'hFFFF) ? reject_cnt : reject_cnt + 16'd1;
            end
         end
      end else if (rnd.rnd_ready) begin
         valid_n = 1'b0;
         st_n    = FILL;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= FILL;
         lfsr_state  <= DEFAULT_SEED;
         data_q      <= '0;
         valid_q     <= 1'b0;
         reject_cnt  <= '0;
         lockup_flag <= 1'b0;
      end else begin
         st          <= st_n;
         lfsr_state  <= lfsr_n;
         data_q      <= data_n;
         valid_q     <= valid_n;
         reject_cnt  <= rej_n;
         lockup_flag <= lock_n;
      end
   end
   assign rnd.rnd_valid = valid_q;
   assign rnd.rnd_data  = data_q;
endmodule

// File: tb/tb_rand_range_gen.sv
// tb_rand_range_gen: table-driven and scoreboard checks of rand_range_gen
module tb_rand_range_gen;
   logic        clk = 1'b0, reset = 1'b1, seed_load = 1'b0;
   logic [15:0] seed_in = '0;
   logic [7:0]  bound = 8'hFF;
   logic [15:0] lfsr_state, reject_cnt;
   logic        lockup_flag;
   int          total = 0, bad = 0;
   logic [7:0]  sb[$];

   typedef struct {
      logic [15:0] seed;
      logic [7:0]  bound;
      int          n;
      logic [7:0]  first;
      logic [15:0] rej;
      int          gap;
   } vec_t;

   rand_range_gen_if #(.OUT_W(8)) rif();

   rand_range_gen #(.OUT_W(8), .DEFAULT_SEED(16'hACE1)) dut (
      .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .bound(bound),
      .rnd(rif), .lfsr_state(lfsr_state), .reject_cnt(reject_cnt), .lockup_flag(lockup_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] nxt(input logic [15:0] s);
      return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
   endfunction

   function automatic logic [7:0] mask_of(input logic [7:0] b);
      logic [8:0] m;
      m = '0;
      while (m < {1'b0, b}) m = {m[7:0], 1'b1};
      return m[7:0];
   endfunction

   task automatic predict(input logic [15:0] seed, input logic [7:0] b, input int n, output logic [15:0] rej);
      logic [15:0] s;
      logic [7:0]  c;
      int          k;
      s = seed;
      rej = '0;
      k = 0;
      while (k < n) begin
         c = s[7:0] & mask_of(b);
         s = nxt(s);
         if (c <= b) begin
            sb.push_back(c);
            k++;
         end else rej++;
      end
   endtask

   task automatic apply_seed(input logic [15:0] s, input logic [7:0] b);
      @(negedge clk);
      seed_in = s;
      bound = b;
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
   endtask

   task automatic consume(input string tag, input int n, input logic [15:0] rej_exp, input int gap_exp, output logic [7:0] first);
      int         got, cyc, last;
      logic [7:0] e;
      got = 0;
      cyc = 0;
      last = -1;
      first = '0;
      rif.rnd_ready = 1'b1;
      while (got < n && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (rif.rnd_valid) begin
            e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            check({tag, " data"}, 32'(rif.rnd_data), 32'(e));
            if (got == 0) first = rif.rnd_data;
            if (got == n - 1) check({tag, " reject_cnt"}, 32'(reject_cnt), 32'(rej_exp));
            if (gap_exp != 0 && last >= 0) check({tag, " gap"}, 32'(cyc - last), 32'(gap_exp));
            last = cyc;
            got++;
         end
      end
      if (got < n) check({tag, " timeout"}, 32'(got), 32'(n));
      @(posedge clk);
      #1 rif.rnd_ready = 1'b0;
   endtask

   initial begin
      vec_t        tbl[5];
      logic [7:0]  f;
      logic [15:0] r;
      tbl[0] = '{16'hACE1, 8'd255, 3, 8'hE1, 16'd0, 2};
      tbl[1] = '{16'hACE1, 8'd2,   4, 8'h01, 16'd3, 0};
      tbl[2] = '{16'hACE1, 8'd0,   6, 8'h00, 16'd0, 2};
      tbl[3] = '{16'h1234, 8'd15,  4, 8'h04, 16'd0, 2};
      tbl[4] = '{16'h1234, 8'd255, 2, 8'h34, 16'd0, 2};
      rif.rnd_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset valid", 32'(rif.rnd_valid), 32'd0);
      check("reset data", 32'(rif.rnd_data), 32'd0);
      check("reset lfsr", 32'(lfsr_state), 32'hACE1);
      check("reset reject_cnt", 32'(reject_cnt), 32'd0);
      check("reset lockup_flag", 32'(lockup_flag), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("first valid", 32'(rif.rnd_valid), 32'd1);
      check("first data", 32'(rif.rnd_data), 32'hE1);
      check("first lfsr", 32'(lfsr_state), 32'h59C2);
      repeat (10) begin
         @(negedge clk);
         check("hold valid", 32'(rif.rnd_valid), 32'd1);
         check("hold data", 32'(rif.rnd_data), 32'hE1);
         check("hold lfsr", 32'(lfsr_state), 32'h59C2);
      end
      rif.rnd_ready = 1'b1;
      @(posedge clk);
      #1 rif.rnd_ready = 1'b0;
      sb.push_back(8'hC2);
      sb.push_back(8'h85);
      consume("post-hold", 2, 16'd0, 2, f);
      for (int i = 0; i < 5; i++) begin
         apply_seed(tbl[i].seed, tbl[i].bound);
         predict(tbl[i].seed, tbl[i].bound, tbl[i].n, r);
         consume($sformatf("row%0d", i), tbl[i].n, tbl[i].rej, tbl[i].gap, f);
         check($sformatf("row%0d first", i), 32'(f), 32'(tbl[i].first));
      end
      apply_seed(16'hACE1, 8'd2);
      predict(16'hACE1, 8'd2, 4, r);
      consume("pre-reset", 4, 16'd3, 0, f);
      @(negedge clk);
      bound = 8'd255;
      reset = 1'b1;
      #1;
      check("midreset valid", 32'(rif.rnd_valid), 32'd0);
      check("midreset data", 32'(rif.rnd_data), 32'd0);
      check("midreset lfsr", 32'(lfsr_state), 32'hACE1);
      check("midreset reject_cnt", 32'(reject_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rerun valid", 32'(rif.rnd_valid), 32'd1);
      check("rerun data", 32'(rif.rnd_data), 32'hE1);
      @(negedge clk);
      seed_in = 16'h1234;
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      check("reseed drop valid", 32'(rif.rnd_valid), 32'd0);
      check("reseed lfsr", 32'(lfsr_state), 32'h1234);
      check("reseed reject_cnt", 32'(reject_cnt), 32'd0);
      @(negedge clk);
      check("reseed valid", 32'(rif.rnd_valid), 32'd1);
      check("reseed data", 32'(rif.rnd_data), 32'h34);
      apply_seed(16'hFFFF, 8'd254);
`ifdef RNG_LOCKUP_RECOVER_EN
      @(negedge clk);
      check("lockup flag", 32'(lockup_flag), 32'd1);
      check("lockup lfsr", 32'(lfsr_state), 32'hACE1);
      check("lockup reject_cnt", 32'(reject_cnt), 32'd0);
      check("lockup valid", 32'(rif.rnd_valid), 32'd0);
      @(negedge clk);
      check("recovered valid", 32'(rif.rnd_valid), 32'd1);
      check("recovered data", 32'(rif.rnd_data), 32'hE1);
      check("recovered flag", 32'(lockup_flag), 32'd1);
      apply_seed(16'hACE1, 8'd255);
      check("flag cleared", 32'(lockup_flag), 32'd0);
`else
      repeat (5) begin
         @(negedge clk);
         check("lockup valid", 32'(rif.rnd_valid), 32'd0);
      end
      check("lockup reject_cnt", 32'(reject_cnt), 32'd5);
      check("lockup lfsr", 32'(lfsr_state), 32'hFFFF);
      check("lockup flag", 32'(lockup_flag), 32'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
